// File: rtl/digit_scan_mux_if.sv
// digit_scan_mux_if: result inputs and multiplexed digit outputs of the display scanner
interface digit_scan_mux_if;
  logic LE;
  logic DU;
  logic HALF;
  logic [3:0] D2;
  logic [3:0] D3;
  logic [3:0] D4;
  logic POL;
  logic OVR;
  logic UNR;
  logic [3:0] Q;
  logic DS1;
  logic DS2;
  logic DS3;
  logic DS4;
  logic FRM;
  modport master (
    output LE, DU, HALF, D2, D3, D4, POL, OVR, UNR,
    input Q, DS1, DS2, DS3, DS4, FRM
  );
  modport slave (
    input LE, DU, HALF, D2, D3, D4, POL, OVR, UNR,
    output Q, DS1, DS2, DS3, DS4, FRM
  );
endinterface

// File: rtl/digit_scan_mux.sv
// digit_scan_mux: double-buffers a 3.5-digit BCD result and scans it onto a strobed digit bus
module digit_scan_mux #(
  parameter int DIGIT_CYC = 18,
  parameter int BLANK_CYC = 2
) (
  input logic CP15,
  input logic R,
  digit_scan_mux_if.slave bus
);
  localparam int MAXC = DIGIT_CYC > BLANK_CYC ? DIGIT_CYC : BLANK_CYC;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {BLK1, S1, BLK2, S2, BLK3, S3, BLK4, S4} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic le_q, pend, cap, adv, enter_s1;
  logic [15:0] pend_d, disp, disp_nxt;
  logic [3:0] q_nxt;
  // cnt is 1-based within a state; reset value 0 makes the first edge count as entering BLK1
  always_comb begin
    adv = cnt >= CW'(state[0] ? DIGIT_CYC : BLANK_CYC);
    nxt = adv ? state_t'(state + ((BLANK_CYC == 0 && state[0]) ? 3'd2 : 3'd1)) : state;
    cnt_nxt = adv ? CW'(1) : cnt + 1'b1;
    enter_s1 = adv && nxt == S1;
    cap = bus.LE && !le_q && bus.DU;
    disp_nxt = (enter_s1 && pend) ? pend_d : disp;
    q_nxt = nxt == S1 ? {~disp_nxt[15], disp_nxt[14], 1'b0, disp_nxt[13] | disp_nxt[12]} :
            nxt == S2 ? disp_nxt[11:8] :
            nxt == S3 ? disp_nxt[7:4] :
            nxt == S4 ? disp_nxt[3:0] : 4'd0;
  end
  always_ff @(posedge CP15 or negedge R) begin
    if (!R) begin
      state <= BLK1;
      cnt <= '0;
      le_q <= 1'b0;
      pend <= 1'b0;
      pend_d <= '0;
      disp <= '0;
      bus.Q <= 4'd0;
      bus.DS1 <= 1'b0;
      bus.DS2 <= 1'b0;
      bus.DS3 <= 1'b0;
      bus.DS4 <= 1'b0;
      bus.FRM <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      le_q <= bus.LE;
      disp <= disp_nxt;
      pend <= cap | (pend & ~enter_s1);
      if (cap) pend_d <= {bus.HALF, bus.POL, bus.OVR, bus.UNR, bus.D2, bus.D3, bus.D4};
      bus.Q <= q_nxt;
      bus.DS1 <= nxt == S1;
      bus.DS2 <= nxt == S2;
      bus.DS3 <= nxt == S3;
      bus.DS4 <= nxt == S4;
      bus.FRM <= enter_s1;
    end
  end
endmodule

// File: doc/digit_scan_mux.md
Name: digit_scan_mux

Overview:
- Output stage of the MC14433 model. Sits directly downstream of the shift/count chain, which produces a 3½-digit BCD result plus polarity and range flags and pulses a latch strobe at end of conversion.
- Double-buffers the result and time-multiplexes it onto a 4-bit digit bus, with one-hot digit strobes DS1..DS4 (DS1 is the MSD).
- A new result reaches the display only at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
- DIGIT_CYC, 18, CP15 cycles each digit strobe stays high. Must be ≥ 1.
- BLANK_CYC, 2, inter-digit blanking cycles before each strobe. Must be ≥ 0; 0 removes the blank state.

Ports:
- CP15  in  1  system clock; all state changes on the rising edge.
- R  in  1  reset, asynchronous, active-low.
- LE  in  1  latch strobe from the upstream stage, level input; its rising edge is detected synchronously.
- DU  in  1  display-update enable; while 0, LE edges are ignored.
- HALF  in  1  half-digit (thousands) value, 0 or 1.
- D2  in  4  hundreds BCD.
- D3  in  4  tens BCD.
- D4  in  4  units BCD.
- POL  in  1  polarity, 1 = positive.
- OVR  in  1  overrange flag.
- UNR  in  1  underrange flag.
- Q  out  4  multiplexed digit data.
- DS1  out  1  MSD strobe.
- DS2  out  1  hundreds strobe.
- DS3  out  1  tens strobe.
- DS4  out  1  units strobe.
- FRM  out  1  one-cycle pulse on the clock that DS1 rises.

Behaviour:
- Reset (R=0, asynchronous):
  - Q=0000; DS1..DS4=0; FRM=0.
  - Pending and display registers cleared; pend flag=0; LE edge-detect history=0.
  - Sequencer state = BLK1, cycle counter=0.
- Sequencer states: BLK1→S1→BLK2→S2→BLK3→S3→BLK4→S4→BLK1…
  - Each BLKn lasts BLANK_CYC cycles; each Sn lasts DIGIT_CYC cycles.
  - BLANK_CYC=0: Sn goes straight to Sn+1 and BLKn states never occur.
  - Frame length = 4·(DIGIT_CYC+BLANK_CYC) cycles (80 at defaults).
  - After R deasserts, the first DS1 rises BLANK_CYC cycles after the first active edge.
- Outputs are registered; DSn is high exactly while the state is Sn, so at most one strobe is high at any time.
- Q during blanking = 0000.
- Q during S1:
  - Q[3] = ~HALF_disp (MC14433 convention: 0 means digit 1).
  - Q[2] = POL_disp.
  - Q[1] = 0.
  - Q[0] = OVR_disp | UNR_disp.
- Q during S2, S3, S4 = D2_disp, D3_disp, D4_disp. Codes above 9 pass through unmodified.
- Latch path:
  - An LE rise is LE=1 sampled this edge with LE=0 sampled the previous edge.
  - LE rise with DU=1: capture all inputs into the pending register and set pend=1.
  - LE rise with DU=0: no capture; pend unchanged.
  - LE held high produces no further captures.
- Transfer path:
  - On the edge that enters S1, if pend=1: display ← pending, pend ← 0.
  - FRM is asserted on that same edge whether or not a transfer occurs.
  - The new data is visible on Q on the first cycle DS1 is high.
- Simultaneous capture and transfer on the same edge:
  - The transfer uses the old pending contents.
  - The new capture overwrites pending and pend stays 1.
  - Display picks up the new data at the next frame.
- Multiple captures within one frame: the last capture wins.
- Reset mid-scan: all strobes drop immediately, both registers clear, and the scan restarts from BLK1.

Test Plan:
1. Reset release at defaults, no LE → first DS1 rises 2 cycles after the first edge. DS1..DS4 each high 18 cycles, with 2-cycle gaps, period 80. Q=1000 during DS1 (display cleared, so HALF=0 gives Q[3]=1) and 0000 elsewhere. FRM pulses once per 80 cycles.
2. LE pulse with DU=1 during S2; inputs HALF=1, D2=9, D3=4, D4=7, POL=1, OVR=0 → remainder of the current frame unchanged. Next frame: DS1 Q=0100, DS2 Q=1001, DS3 Q=0100, DS4 Q=0111.
3. LE pulse with DU=0, then LE held high across two frames with DU=1 → no capture from the first pulse; exactly one capture from the held level; display updates once.
4. Two captures in one frame (values 123, then 456 in D2..D4) → next frame shows 456 only.
5. LE rise on the same edge that enters S1 → that frame shows the previous pending value; the following frame shows the new one.
6. R pulsed low for 3 cycles during DS3 → DS3 drops asynchronously and Q=0000. Display clears (DS1 Q=1000). Scan restarts with DS1 rising 2 cycles after release.
